bpu_gshare_btb: RTL

- Parametrised branch prediction unit for the 5-stage RV32I pipeline, replacing the fixed 2-bit predictor/BTB pair.
- Direct-mapped BTB with configurable depth and tag width, plus a pattern history table (PHT) of configurable-width saturating counters.
- Selectable bimodal or gshare PHT indexing, and branch/mispredict performance counters.
- Lookup is combinational in IF; updates arrive from EX at branch resolution.

---
 rtl/bpu_if.sv | 34 +++
 rtl/bpu_gshare_btb.sv | 109 ++++++++++
 2 files changed

// File: rtl/bpu_if.sv
// Predictor port bundle: IF-stage lookup, EX-stage resolution update, flush and perf counters.
// The slave modport is the predictor side; the master modport is the pipeline side.
interface bpu_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
);
  logic [XLEN-1:0]  pc_i;
  logic             pred_hit_o;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_next_pc_o;
  logic [IDX_W-1:0] pred_idx_o;
  logic             upd_valid_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_is_cond_i;
  logic             upd_taken_i;
  logic [XLEN-1:0]  upd_target_i;
  logic             upd_mispredict_i;
  logic             flush_i;
  logic [31:0]      br_cnt_o;
  logic [31:0]      miss_cnt_o;

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_idx_i, upd_is_cond_i, upd_taken_i,
           upd_target_i, upd_mispredict_i, flush_i,
    output pred_hit_o, pred_taken_o, pred_next_pc_o, pred_idx_o, br_cnt_o, miss_cnt_o
  );

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_idx_i, upd_is_cond_i, upd_taken_i,
           upd_target_i, upd_mispredict_i, flush_i,
    input  pred_hit_o, pred_taken_o, pred_next_pc_o, pred_idx_o, br_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/bpu_gshare_btb.sv
// Direct-mapped BTB plus saturating-counter PHT with bimodal or gshare indexing.
// Lookup is combinational on pre-update state; updates land on the clock edge.
module bpu_gshare_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6,
  parameter int MODE    = 0
) (
  input logic  clk_i,
  input logic  rst_ni,
  bpu_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] jump_q,  jump_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [CNT_W-1:0]   pht_q [ENTRIES];
  logic [CNT_W-1:0]   pht_d [ENTRIES];
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic [31:0]        br_q, br_d;
  logic [31:0]        miss_q, miss_d;

  logic [IDX_W-1:0] bidx, pidx, ubidx;
  logic [TAG_W-1:0] ltag, utag;
  logic             hit, taken;

  assign bidx  = bus.pc_i[IDX_W+1:2];
  assign ltag  = bus.pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign ubidx = bus.upd_pc_i[IDX_W+1:2];
  assign utag  = bus.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign pidx  = (MODE == 1) ? (bidx ^ IDX_W'(ghr_q)) : bidx;

  assign hit   = valid_q[bidx] && (tag_q[bidx] == ltag);
  assign taken = hit && (jump_q[bidx] || pht_q[pidx][CNT_W-1]);

  assign bus.pred_hit_o     = hit;
  assign bus.pred_taken_o   = taken;
  assign bus.pred_next_pc_o = taken ? tgt_q[bidx] : (bus.pc_i + XLEN'(4));
  assign bus.pred_idx_o     = pidx;
  assign bus.br_cnt_o       = br_q;
  assign bus.miss_cnt_o     = miss_q;

  logic unused_pc;
  assign unused_pc = ^{bus.pc_i[XLEN-1:IDX_W+TAG_W+2], bus.pc_i[1:0],
                       bus.upd_pc_i[XLEN-1:IDX_W+TAG_W+2], bus.upd_pc_i[1:0]};

  always_comb begin
    valid_d = valid_q;
    jump_d  = jump_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    pht_d   = pht_q;
    ghr_d   = ghr_q;
    br_d    = br_q;
    miss_d  = miss_q;
    if (bus.upd_valid_i) begin
      if (bus.upd_is_cond_i) begin
        if (bus.upd_taken_i && (pht_q[bus.upd_idx_i] != CNT_MAX))
          pht_d[bus.upd_idx_i] = pht_q[bus.upd_idx_i] + 1'b1;
        else if (!bus.upd_taken_i && (pht_q[bus.upd_idx_i] != '0))
          pht_d[bus.upd_idx_i] = pht_q[bus.upd_idx_i] - 1'b1;
        ghr_d = GHR_W'({ghr_q, bus.upd_taken_i});
        if (br_q != '1) br_d = br_q + 32'd1;
      end
      // Only taken outcomes allocate; a not-taken branch leaves any existing entry alone.
      if (bus.upd_taken_i) begin
        valid_d[ubidx] = 1'b1;
        jump_d[ubidx]  = ~bus.upd_is_cond_i;
        tag_d[ubidx]   = utag;
        tgt_d[ubidx]   = bus.upd_target_i;
      end
      if (bus.upd_mispredict_i && (miss_q != '1)) miss_d = miss_q + 32'd1;
    end
    if (bus.flush_i) begin
      valid_d = '0;
      ghr_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      jump_q  <= '0;
      tag_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      pht_q   <= '{default: CNT_INIT};
      ghr_q   <= '0;
      br_q    <= '0;
      miss_q  <= '0;
    end else begin
      valid_q <= valid_d;
      jump_q  <= jump_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      pht_q   <= pht_d;
      ghr_q   <= ghr_d;
      br_q    <= br_d;
      miss_q  <= miss_d;
    end
  end
endmodule
